// File: rtl/branch_pkg.sv
// Shared encodings for the ID-stage branch resolution logic.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_OPS = 2'b01,
    REDIRECT = 2'b10
  } br_state_e;

  function automatic logic br_op_active(input logic [2:0] op);
    return (op != BR_NONE) && (op != BR_RSVD);
  endfunction

endpackage

// File: rtl/branch_cond_compare.sv
// Combinational branch condition evaluation on two's-complement operands.
module branch_cond_compare
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic [2:0]            br_op,
  output logic                  taken
);

  logic rs_neg;
  logic rs_zero;

  // Zero-compare branches only need the sign bit and a zero detect.
  assign rs_neg  = rs_data[DATA_WIDTH-1];
  assign rs_zero = (rs_data == '0);

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_BEQ:  taken = (rs_data == rt_data);
      BR_BNE:  taken = (rs_data != rt_data);
      BR_BLEZ: taken = rs_neg || rs_zero;
      BR_BGTZ: taken = !rs_neg && !rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: condition check, operand-wait stall, registered
// one-cycle PC redirect with IF flush, and saturating branch statistics.
//
// state    | meaning
// IDLE     | no branch pending; resolves immediately when operands are ready
// WAIT_OPS | branch held in ID, stalling until forwarding reports ready
// REDIRECT | taken branch: redirect PC and flush IF for one cycle
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int IMM_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_valid,
  input  logic [2:0]            br_op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  ops_ready,
  input  logic [PC_WIDTH-1:0]   pc_plus4,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic                  cnt_clr,
  output logic                  stall_id,
  output logic                  redirect_valid,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  flush_if,
  output logic [CNT_WIDTH-1:0]  br_count,
  output logic [CNT_WIDTH-1:0]  taken_count
);

  br_state_e            state_q, state_d;
  logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
  logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;

  logic                active;
  logic                taken;
  logic                resolve;
  logic [PC_WIDTH-1:0] imm_ext;
  logic [PC_WIDTH-1:0] target;

  branch_cond_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .rs_data (rs_data),
    .rt_data (rt_data),
    .br_op   (br_op),
    .taken   (taken)
  );

  assign active  = br_valid && br_op_active(br_op);
  assign imm_ext = {{(PC_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign target  = pc_plus4 + (imm_ext << 2);
  // REDIRECT is never a resolve cycle: its br_valid is the wrong-path slot.
  assign resolve = active && ops_ready && ((state_q == IDLE) || (state_q == WAIT_OPS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (active) state_d = ops_ready ? (taken ? REDIRECT : IDLE) : WAIT_OPS;
      end
      WAIT_OPS: begin
        if (!active)        state_d = IDLE;
        else if (ops_ready) state_d = taken ? REDIRECT : IDLE;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    redirect_pc_d = redirect_pc_q;
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (resolve && taken) redirect_pc_d = target;
    if (cnt_clr) begin
      br_count_d    = '0;
      taken_count_d = '0;
    end else if (resolve) begin
      if (br_count_q != '1)             br_count_d    = br_count_q + 1'b1;
      if (taken && taken_count_q != '1) taken_count_d = taken_count_q + 1'b1;
    end
  end

  always_comb begin
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    flush_if       = 1'b0;
    case (state_q)
      IDLE:     stall_id = reset && active && !ops_ready;
      WAIT_OPS: stall_id = reset && !ops_ready;
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush_if       = 1'b1;
      end
      default: ;
    endcase
  end

  assign redirect_pc = redirect_pc_q;
  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised ID-stage branch resolution for the MIPS pipeline; next generation of the single-bit BEQ/BNE equality decision.
- Evaluates six branch conditions on register operands and stalls while operands are still pending from the hazard/forwarding logic.
- Issues a registered one-cycle PC redirect with an IF flush, and keeps saturating branch/taken statistics counters.

Parameters:
- DATA_WIDTH, 32, width of compared operands (two's complement)
- PC_WIDTH, 32, width of PC and branch target
- IMM_WIDTH, 16, width of branch offset immediate (word offset)
- CNT_WIDTH, 16, width of each statistics counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- br_valid  in  1  ID holds a branch instruction this cycle
- br_op  in  3  condition code: 000 NONE, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 BLTZ, 110 BGEZ, 111 reserved
- rs_data  in  DATA_WIDTH  first operand (forwarded)
- rt_data  in  DATA_WIDTH  second operand (forwarded; used by BEQ/BNE only)
- ops_ready  in  1  forwarding unit: both operands final this cycle
- pc_plus4  in  PC_WIDTH  PC+4 of the branch
- imm  in  IMM_WIDTH  signed word offset
- cnt_clr  in  1  synchronous clear of the statistics counters
- stall_id  out  1  hold IF/ID and bubble ID/EX (combinational)
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  PC_WIDTH  branch target
- flush_if  out  1  squash the IF/ID register (same cycle as redirect_valid)
- br_count  out  CNT_WIDTH  branches resolved
- taken_count  out  CNT_WIDTH  branches taken

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; redirect_valid=0, flush_if=0, redirect_pc=0, br_count=0, taken_count=0. stall_id=0 while reset is asserted.
- Active branch: br_valid=1 and br_op in 001..110. NONE and reserved codes (000, 111) are never active branches.
- Conditions:
  - BEQ: rs==rt
  - BNE: rs!=rt
  - BLEZ: rs<=0 (signed)
  - BGTZ: rs>0
  - BLTZ: rs<0
  - BGEZ: rs>=0
- Target: pc_plus4 + (sign_extend(imm) << 2), truncated to PC_WIDTH (wraps modulo 2^PC_WIDTH).
- FSM states:
  - IDLE: active branch with ops_ready=1 resolves this cycle. If taken, go to REDIRECT; if not taken, stay in IDLE. Active branch with ops_ready=0 goes to WAIT_OPS.
  - WAIT_OPS: held instruction; resolves on the first cycle ops_ready=1, with the same taken/not-taken split as IDLE. If br_valid drops (external flush), return to IDLE with no resolve and no count.
  - REDIRECT: redirect_valid=1, flush_if=1 for exactly one cycle, then IDLE. Any br_valid in this cycle is the wrong-path instruction: ignored, not counted, no stall.
- stall_id = (IDLE and active branch and !ops_ready) or (WAIT_OPS and !ops_ready).
- Latency: resolve cycle N gives redirect_valid and flush_if in cycle N+1. redirect_pc is captured at resolve and held until the next taken resolve.
- Counters:
  - Each resolve increments br_count; a taken resolve also increments taken_count.
  - Both saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- Back-to-back: a not-taken resolve in IDLE can be followed by a new resolve in the next cycle.

Decomposition:
- Shared package branch_pkg:
  - br_op encodings (BR_NONE..BR_BGEZ)
  - FSM state encoding (IDLE, WAIT_OPS, REDIRECT)
- Sub-module branch_cond_compare: purely combinational. Inputs rs_data, rt_data, br_op; output taken. Reserved and NONE codes give taken=0.
- FSM, target adder and counters live in the top module.

Test Plan:
- Reset released; BEQ with rs=rt=32'h1234, ops_ready=1, pc_plus4=32'h0040_0010, imm=16'h0004 -> next cycle redirect_valid=1, flush_if=1, redirect_pc=32'h0040_0020, br_count=1, taken_count=1.
- BNE with rs=5, rt=5 -> no redirect, no stall, br_count increments, taken_count unchanged; an immediately following BGTZ with rs=1 resolves taken the next cycle.
- BLTZ with rs=32'hFFFF_FFFF and ops_ready low for 3 cycles -> stall_id=1 for those 3 cycles, then resolves taken; redirect one cycle after ops_ready rises. imm=16'hFFFE gives redirect_pc=pc_plus4-8.
- Signed edges: BLEZ rs=0 -> taken; BGEZ rs=32'h8000_0000 -> not taken; br_op=111 -> no stall, no count, no redirect.
- Wrap and saturation:
  - pc_plus4=32'hFFFF_FFFC, imm=1 -> redirect_pc=0.
  - Counters preset near all-ones with CNT_WIDTH=4 -> hold at 4'hF.
  - cnt_clr together with a resolve -> counters read 0.
- reset asserted mid-WAIT_OPS, and separately mid-REDIRECT -> outputs go to 0 immediately; after release, the FSM is in IDLE and a new branch resolves normally.
